tri_bus_port: RTL and testbench
===============================

TRI_BUS_PORT -- requirements
Module: tri_bus_port

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the shared tri-state bus and of the tx/rx data ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  asynchronous active-low reset (clear).
REQ-004 tx_data  input  WIDTH  word to place on the bus.
REQ-005 tx_valid  input  1  tx_data valid; transfer accepted when tx_valid & tx_ready at a rising edge.
REQ-006 tx_ready  output  1  port idle and able to accept a word.
REQ-007 bus_req  output  1  request for bus ownership to the external arbiter.
REQ-008 bus_gnt  input  1  grant from the arbiter.
REQ-009 bus  inout  WIDTH  shared tri-state data bus, driven only while owned, else high-Z.
REQ-010 bus_stb  inout  1  shared tri-state strobe, 1 marks a valid bus word, high-Z when not owned.
REQ-011 rx_data  output  WIDTH  last word captured from another driver.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_data newly updated.
REQ-013 tx_err  output  1  one-cycle pulse on grant timeout (only with TRI_BUS_GNT_TIMEOUT_EN).

Function
REQ-014 FSM states IDLE, REQ, DRIVE, TURN; the FSM SHALL be encoded in registers clocked by clk.
REQ-015 IDLE: tx_ready=1; on tx_valid, latch tx_data into a holding register and go to REQ; bus_gnt ignored in IDLE.
REQ-016 REQ: bus_req=1; on bus_gnt=1 go to DRIVE, else stay.
REQ-017 DRIVE: exactly one cycle; bus SHALL carry the held word and bus_stb SHALL be 1; bus_req stays 1; next state TURN.
REQ-018 TURN: bus and bus_stb SHALL be high-Z, bus_req=0; next state IDLE (one-cycle turnaround, no back-to-back ownership).
REQ-019 Output enable SHALL be a register, set only while in DRIVE; bus/bus_stb SHALL be high-Z in every other state.
REQ-020 tx_ready SHALL be 1 only in IDLE; accept-to-drive latency is 1 cycle plus the grant wait (minimum 2 cycles with bus_gnt already high).
REQ-021 Receive: at a rising edge where bus_stb==1 and own output enable==0, rx_data SHALL capture bus and rx_valid SHALL be 1 for the following cycle only.
REQ-022 Own DRIVE words SHALL NOT be captured (no loopback); bus_stb high-Z or 0 SHALL NOT capture.
REQ-023 Held word SHALL be unchanged from acceptance until leaving DRIVE, regardless of tx_data.
REQ-024 bus_gnt deassertion during DRIVE SHALL NOT shorten the DRIVE cycle.

Reset
REQ-025 clrn=0 SHALL immediately (no clock) force state IDLE, output enable 0 (bus, bus_stb high-Z), bus_req=0, rx_valid=0, tx_err=0, rx_data=0, holding register=0, timeout counter=0.
REQ-026 tx_ready SHALL be 0 while clrn=0 and 1 in the first cycle after release.
REQ-027 Reset during REQ or DRIVE SHALL abandon the word with no strobe emitted afterwards.

Configuration
REQ-028 Macro TRI_BUS_GNT_TIMEOUT_EN: when defined, a 4-bit counter SHALL run in REQ; if bus_gnt has not been seen when the counter reaches 15, FSM SHALL return to IDLE (word dropped) and tx_err SHALL pulse for one cycle.
REQ-029 bus_gnt=1 in the same cycle the counter reaches 15 SHALL win (go to DRIVE, no tx_err); counter SHALL clear on entry to REQ.
REQ-030 Without the macro: no counter, REQ waits indefinitely, tx_err SHALL be tied to 0.

Verification
REQ-031 Reset mid-DRIVE: clrn pulled low during DRIVE -> bus and bus_stb high-Z within same time step, bus_req=0, tx_ready=1 after release.
REQ-032 Basic send: bus_gnt held 1, tx_data=8'hA5 with tx_valid -> bus=8'hA5 and bus_stb=1 for exactly one cycle 2 cycles later, then high-Z, tx_ready back after TURN.
REQ-033 Delayed grant: bus_gnt asserted 5 cycles after accept -> DRIVE in cycle after grant; tx_data changed to 8'h00 meanwhile -> bus still 8'hA5.
REQ-034 Receive: external driver places 8'h3C with bus_stb=1 for one cycle while port idle -> rx_data=8'h3C, rx_valid=1 for one cycle; own DRIVE never raises rx_valid.
REQ-035 Timeout (macro defined): bus_gnt held 0 -> tx_err pulse 15 cycles after entering REQ, FSM in IDLE, bus never driven; grant on cycle 15 -> DRIVE, no tx_err.
REQ-036 Timeout (macro undefined): bus_gnt held 0 for 100 cycles -> bus_req stays 1, tx_err stays 0.

Source files
------------

// File: rtl/tri_bus_port.sv
// Tri-state bus port: arbitrated one-word transmit onto a shared bus plus passive receive.
// Optional grant timeout enabled by defining TRI_BUS_GNT_TIMEOUT_EN.
module tri_bus_port #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  inout  wire  [WIDTH-1:0] bus,
  inout  wire              bus_stb,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             hold_ld;
  logic             oe;
  logic [WIDTH-1:0] hold;

`ifdef TRI_BUS_GNT_TIMEOUT_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(15);

  logic [CNT_W-1:0] cnt;
  logic             timeout;
`endif

  // Next-state decode; the timeout only fires when no grant arrives in the same cycle.
  always_comb begin
    state_nxt = state;
    hold_ld   = 1'b0;
`ifdef TRI_BUS_GNT_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt = S_REQ;
          hold_ld   = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_nxt = S_DRIVE;
        end
`ifdef TRI_BUS_GNT_TIMEOUT_EN
        else if (cnt == CNT_TIMEOUT - CNT_W'(1)) begin
          state_nxt = S_IDLE;
          timeout   = 1'b1;
        end
`endif
      end
      S_DRIVE: state_nxt = S_TURN;
      S_TURN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      oe      <= 1'b0;
      bus_req <= 1'b0;
      hold    <= '0;
    end else begin
      state   <= state_nxt;
      oe      <= (state_nxt == S_DRIVE);
      bus_req <= (state_nxt == S_REQ) || (state_nxt == S_DRIVE);
      if (hold_ld) begin
        hold <= tx_data;
      end
    end
  end

  // Capture only words placed on the bus by some other driver.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((bus_stb == 1'b1) && !oe) begin
        rx_data  <= bus;
        rx_valid <= 1'b1;
      end
    end
  end

`ifdef TRI_BUS_GNT_TIMEOUT_EN
  // Counts grant-less REQ cycles; held at zero outside REQ so every entry starts fresh.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      tx_err <= 1'b0;
    end else begin
      tx_err <= timeout;
      if (state != S_REQ) begin
        cnt <= '0;
      end else if (!bus_gnt) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  assign tx_err = 1'b0;
`endif

  // Ready is gated by clear so it reads 0 while reset is held.
  assign tx_ready = clrn & (state == S_IDLE);
  assign bus      = oe ? hold : {WIDTH{1'bz}};
  assign bus_stb  = oe ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_tri_bus_port.sv
// Bench for tri_bus_port: randomized sends/receives checked against a cycle-count model.
// Timeout scenarios follow TRI_BUS_GNT_TIMEOUT_EN.
module tb_tri_bus_port;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             clrn;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             bus_req;
  logic             bus_gnt;
  wire  [WIDTH-1:0] bus;
  wire              bus_stb;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_err;

  logic             ext_oe;
  logic [WIDTH-1:0] ext_data;
  logic             ext_stb_oe;
  logic             ext_stb;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] exp_rx;

  assign bus     = ext_oe ? ext_data : {WIDTH{1'bz}};
  assign bus_stb = ext_stb_oe ? ext_stb : 1'bz;

  always #5 clk = ~clk;

  tri_bus_port #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .bus      (bus),
    .bus_stb  (bus_stb),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_err   (tx_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Briefly drive zeros from outside; a port that is truly released leaves exactly zeros.
  task automatic probe_released(input string tag);
    ext_data = '0;
    ext_oe   = 1'b1;
    #1;
    n_tests++;
    if (bus !== '0 || bus_stb === 1'b1) begin
      n_fail++;
      $display("FAIL %s_released: bus=%h stb=%b want bus=00 stb!=1", tag, bus, bus_stb);
    end
    ext_oe = 1'b0;
  endtask

  // One full transmit: accept, w grant-less REQ cycles, one DRIVE cycle, TURN, back to IDLE.
  task automatic send_word(input logic [WIDTH-1:0] word, input int w,
                           input logic [WIDTH-1:0] later, input bit drop);
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: tx_ready=%b want 1", tx_ready);
    end
    tx_data  = word;
    tx_valid = 1'b1;
    bus_gnt  = 1'(w == 0);
    tick();
    tx_valid = 1'b0;
    tx_data  = later;
    n_tests++;
    if (bus_req !== 1'b1 || tx_ready !== 1'b0 || bus_stb === 1'b1) begin
      n_fail++;
      $display("FAIL send_req: req=%b ready=%b stb=%b want 1 0 !1", bus_req, tx_ready, bus_stb);
    end
    for (int i = 0; i < w; i++) begin
      tick();
      n_tests++;
      if (bus_req !== 1'b1 || tx_ready !== 1'b0 || bus_stb === 1'b1 || tx_err !== 1'b0) begin
        n_fail++;
        $display("FAIL send_wait%0d: req=%b ready=%b stb=%b err=%b want 1 0 !1 0",
                 i, bus_req, tx_ready, bus_stb, tx_err);
      end
    end
    bus_gnt = 1'b1;
    tick();
    if (drop) bus_gnt = 1'b0;
    n_tests++;
    if (bus !== word || bus_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL send_drive: bus=%h stb=%b want %h 1", bus, bus_stb, word);
    end
    n_tests++;
    if (bus_req !== 1'b1 || tx_ready !== 1'b0 || tx_err !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL send_drive_ctl: req=%b ready=%b err=%b rxv=%b want 1 0 0 0",
               bus_req, tx_ready, tx_err, rx_valid);
    end
    tick();
    n_tests++;
    if (bus_stb === 1'b1 || bus_req !== 1'b0 || tx_ready !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL send_turn: stb=%b req=%b ready=%b rxv=%b want !1 0 0 0",
               bus_stb, bus_req, tx_ready, rx_valid);
    end
    probe_released("turn");
    bus_gnt = 1'b0;
    tick();
    n_tests++;
    if (tx_ready !== 1'b1 || bus_req !== 1'b0 || rx_valid !== 1'b0 || bus_stb === 1'b1 ||
        rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL send_idle: ready=%b req=%b rxv=%b stb=%b rx=%h want 1 0 0 !1 %h",
               tx_ready, bus_req, rx_valid, bus_stb, rx_data, exp_rx);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; tx_data = '0; tx_valid = 1'b0; bus_gnt = 1'b0;
    ext_oe = 1'b0; ext_data = '0; ext_stb_oe = 1'b0; ext_stb = 1'b0;
    exp_rx = '0;
    #23;
    n_tests++;
    if (tx_ready !== 1'b0 || bus_req !== 1'b0 || rx_valid !== 1'b0 || tx_err !== 1'b0 ||
        rx_data !== '0 || bus_stb === 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b req=%b rxv=%b err=%b rx=%h stb=%b",
               tx_ready, bus_req, rx_valid, tx_err, rx_data, bus_stb);
    end
    probe_released("reset");
    clrn = 1'b1;
    #1;
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: tx_ready=%b want 1", tx_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    send_word(8'hA5, 0, 8'h5A, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(0, 6)), WIDTH'($urandom),
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_delayed_grant();
    send_word(8'hA5, 5, 8'h00, 1'b1);
  endtask

  task automatic test_receive();
    for (int k = 0; k < 6; k++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom);
      if (k == 0) d = 8'h3C;
      repeat ($urandom_range(0, 3)) tick();
      ext_data = d; ext_oe = 1'b1; ext_stb = 1'b1; ext_stb_oe = 1'b1;
      tick();
      ext_oe = 1'b0; ext_stb_oe = 1'b0;
      exp_rx = d;
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== exp_rx) begin
        n_fail++;
        $display("FAIL rx_capture: rxv=%b rx=%h want 1 %h", rx_valid, rx_data, exp_rx);
      end
      tick();
      n_tests++;
      if (rx_valid !== 1'b0 || rx_data !== exp_rx) begin
        n_fail++;
        $display("FAIL rx_pulse: rxv=%b rx=%h want 0 %h", rx_valid, rx_data, exp_rx);
      end
      // A driven word with strobe low must be ignored.
      ext_data = ~d; ext_oe = 1'b1; ext_stb = 1'b0; ext_stb_oe = 1'b1;
      tick();
      ext_oe = 1'b0; ext_stb_oe = 1'b0;
      n_tests++;
      if (rx_valid !== 1'b0 || rx_data !== exp_rx) begin
        n_fail++;
        $display("FAIL rx_stb_low: rxv=%b rx=%h want 0 %h", rx_valid, rx_data, exp_rx);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(0, 14)), WIDTH'($urandom),
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_drive();
    tx_data = 8'hC3; tx_valid = 1'b1; bus_gnt = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    n_tests++;
    if (bus !== 8'hC3 || bus_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_drive: bus=%h stb=%b want c3 1", bus, bus_stb);
    end
    clrn = 1'b0;
    #1;
    n_tests++;
    if (bus_stb === 1'b1 || bus_req !== 1'b0 || tx_ready !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drive: stb=%b req=%b ready=%b rxv=%b want !1 0 0 0",
               bus_stb, bus_req, tx_ready, rx_valid);
    end
    probe_released("rst_drive");
    #10;
    bus_gnt = 1'b0;
    clrn    = 1'b1;
    exp_rx  = '0;
    #1;
    n_tests++;
    if (tx_ready !== 1'b1 || rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL rst_release: ready=%b rx=%h want 1 00", tx_ready, rx_data);
    end
    bus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus_stb === 1'b1 || bus_req !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_abandon%0d: stb=%b req=%b ready=%b want !1 0 1",
                 i, bus_stb, bus_req, tx_ready);
      end
    end
    bus_gnt = 1'b0;
    // Reset while waiting in REQ also drops the word.
    tx_data = 8'h77; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    clrn = 1'b0;
    #3;
    clrn = 1'b1;
    bus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus_stb === 1'b1 || bus_req !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_req_abandon%0d: stb=%b req=%b ready=%b want !1 0 1",
                 i, bus_stb, bus_req, tx_ready);
      end
    end
    bus_gnt = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef TRI_BUS_GNT_TIMEOUT_EN
    tx_data = WIDTH'($urandom); tx_valid = 1'b1; bus_gnt = 1'b0;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k < 15; k++) begin
      tick();
      n_tests++;
      if (bus_req !== 1'b1 || tx_err !== 1'b0 || bus_stb === 1'b1) begin
        n_fail++;
        $display("FAIL to_wait%0d: req=%b err=%b stb=%b want 1 0 !1", k, bus_req, tx_err, bus_stb);
      end
    end
    tick();
    n_tests++;
    if (tx_err !== 1'b1 || tx_ready !== 1'b1 || bus_req !== 1'b0 || bus_stb === 1'b1) begin
      n_fail++;
      $display("FAIL to_fire: err=%b ready=%b req=%b stb=%b want 1 1 0 !1",
               tx_err, tx_ready, bus_req, bus_stb);
    end
    tick();
    n_tests++;
    if (tx_err !== 1'b0 || bus_stb === 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse: err=%b stb=%b want 0 !1", tx_err, bus_stb);
    end
    send_word(WIDTH'($urandom), 14, WIDTH'($urandom), 1'b0);
`else
    tx_data = WIDTH'($urandom); tx_valid = 1'b1; bus_gnt = 1'b0;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      n_tests++;
      if (bus_req !== 1'b1 || tx_err !== 1'b0 || bus_stb === 1'b1) begin
        n_fail++;
        $display("FAIL no_to%0d: req=%b err=%b stb=%b want 1 0 !1", k, bus_req, tx_err, bus_stb);
      end
    end
    clrn = 1'b0;
    #3;
    clrn = 1'b1;
    exp_rx = '0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_grant();
    test_receive();
    test_back_to_back();
    test_reset_mid_drive();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
